spi_input: RTL and testbench

SPI_INPUT -- requirements
Module: spi_input

---
 rtl/spi_input.sv | 182 ++++++++++++++++++
 tb/tb_spi_input.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_input.sv
// Avalon-MM front end for the SPI engine: command registers, a TX data FIFO,
// and the IDLE/ISSUE/RUN sequencer that hands a snapshotted command to the engine.
module spi_input #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        avs_s0_write,
  input  logic        avs_s0_read,
  input  logic [11:0] avs_s0_address,
  input  logic [31:0] avs_s0_writedata,
  output logic        avs_s0_waitrequest,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [23:0] cmd_addr,
  output logic [15:0] cmd_len,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        xfer_done,
  output logic        crc_clear,
  output logic        error_clear,
  output logic        busy,
  output logic        start_reject
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_e;

  state_e state_q, state_d;

  logic [7:0]  opcode_q, opcode_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  cmd_opcode_q, cmd_opcode_d;
  logic [23:0] cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_len_q, cmd_len_d;
  logic        crc_clear_q, crc_clear_d;
  logic        error_clear_q, error_clear_d;
  logic        start_reject_q, start_reject_d;

  logic [FIFO_DEPTH-1:0][31:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic fifo_full, fifo_empty;
  logic wr_acc, push, pop, ctrl_wr, start;
  logic unused_read;

  // Reads are served by the output block; this block only observes writes.
  assign unused_read = avs_s0_read;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);

  // A full FIFO only stalls when nothing is leaving it this same cycle.
  assign avs_s0_waitrequest = avs_s0_write && (avs_s0_address == 12'd3) && fifo_full && !tx_ready;

  assign wr_acc  = avs_s0_write && !avs_s0_waitrequest;
  assign push    = wr_acc && (avs_s0_address == 12'd3);
  assign ctrl_wr = wr_acc && (avs_s0_address == 12'd4);
  assign start   = ctrl_wr && avs_s0_writedata[0];

  assign tx_valid = !fifo_empty;
  assign tx_data  = mem_q[rd_ptr_q];
  assign pop      = tx_valid && tx_ready;

  assign cmd_valid    = (state_q == ISSUE);
  assign busy         = (state_q != IDLE);
  assign cmd_opcode   = cmd_opcode_q;
  assign cmd_addr     = cmd_addr_q;
  assign cmd_len      = cmd_len_q;
  assign crc_clear    = crc_clear_q;
  assign error_clear  = error_clear_q;
  assign start_reject = start_reject_q;

  always_comb begin
    opcode_d = opcode_q;
    addr_d   = addr_q;
    len_d    = len_q;
    if (wr_acc) begin
      case (avs_s0_address)
        12'd0:   opcode_d = avs_s0_writedata[7:0];
        12'd1:   addr_d   = avs_s0_writedata[23:0];
        12'd2:   len_d    = avs_s0_writedata[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = avs_s0_writedata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cmd_opcode_d   = cmd_opcode_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_len_d      = cmd_len_q;
    start_reject_d = 1'b0;
    crc_clear_d    = ctrl_wr && avs_s0_writedata[1];
    error_clear_d  = ctrl_wr && avs_s0_writedata[2];
    case (state_q)
      IDLE: begin
        if (start) begin
          // A zero-length command would never see xfer_done, so refuse it.
          if (len_q != 16'd0) begin
            state_d      = ISSUE;
            cmd_opcode_d = opcode_q;
            cmd_addr_d   = addr_q;
            cmd_len_d    = len_q;
          end else begin
            start_reject_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (start) start_reject_d = 1'b1;
        if (cmd_ready) state_d = RUN;
      end
      RUN: begin
        if (start) start_reject_d = 1'b1;
        if (xfer_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      opcode_q       <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      cmd_opcode_q   <= '0;
      cmd_addr_q     <= '0;
      cmd_len_q      <= '0;
      crc_clear_q    <= 1'b0;
      error_clear_q  <= 1'b0;
      start_reject_q <= 1'b0;
      mem_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      cmd_opcode_q   <= cmd_opcode_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_len_q      <= cmd_len_d;
      crc_clear_q    <= crc_clear_d;
      error_clear_q  <= error_clear_d;
      start_reject_q <= start_reject_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
    end
  end

endmodule

// File: tb/tb_spi_input.sv
// Bench for spi_input: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a queue-based model.
module tb_spi_input;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        avs_s0_write = 1'b0;
  logic        avs_s0_read = 1'b0;
  logic [11:0] avs_s0_address = '0;
  logic [31:0] avs_s0_writedata = '0;
  logic        avs_s0_waitrequest;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_opcode;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        xfer_done = 1'b0;
  logic        crc_clear, error_clear, busy, start_reject;

  int vectors = 0;
  int misses  = 0;

  spi_input #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .avs_s0_write(avs_s0_write), .avs_s0_read(avs_s0_read),
    .avs_s0_address(avs_s0_address), .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_waitrequest(avs_s0_waitrequest),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .xfer_done(xfer_done), .crc_clear(crc_clear), .error_clear(error_clear),
    .busy(busy), .start_reject(start_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = idle, 1 = command offered, 2 = transfer running
  int          m_phase = 0;
  logic [7:0]  m_op = '0, s_op = '0;
  logic [23:0] m_ad = '0, s_ad = '0;
  logic [15:0] m_ln = '0, s_ln = '0;
  logic        m_crc = 0, m_err = 0, m_rej = 0;
  logic [31:0] q[$];

  function automatic bit m_wait();
    return avs_s0_write && (avs_s0_address == 12'd3) && (q.size() == DEPTH) && !tx_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_op = '0; m_ad = '0; m_ln = '0;
      s_op = '0; s_ad = '0; s_ln = '0;
      m_crc = 0; m_err = 0; m_rej = 0;
      q.delete();
    end else begin
      bit acc, popit;
      int nph;
      acc   = avs_s0_write && !m_wait();
      popit = (q.size() != 0) && tx_ready;
      nph   = m_phase;
      m_crc = 0; m_err = 0; m_rej = 0;
      if (m_phase == 1 && cmd_ready) nph = 2;
      else if (m_phase == 2 && xfer_done) nph = 0;
      if (acc) begin
        case (avs_s0_address)
          12'd0: m_op = avs_s0_writedata[7:0];
          12'd1: m_ad = avs_s0_writedata[23:0];
          12'd2: m_ln = avs_s0_writedata[15:0];
          12'd4: begin
            m_crc = avs_s0_writedata[1];
            m_err = avs_s0_writedata[2];
            if (avs_s0_writedata[0]) begin
              if (m_phase == 0 && m_ln != 0) begin
                nph = 1; s_op = m_op; s_ad = m_ad; s_ln = m_ln;
              end else m_rej = 1;
            end
          end
          default: ;
        endcase
      end
      if (popit) void'(q.pop_front());
      if (acc && avs_s0_address == 12'd3) q.push_back(avs_s0_writedata);
      m_phase = nph;
    end
  end

  always @(negedge clk) begin
    chk1("waitrequest", avs_s0_waitrequest, m_wait());
    chk1("busy", busy, m_phase != 0);
    chk1("cmd_valid", cmd_valid, m_phase == 1);
    chk("cmd_opcode", 32'(cmd_opcode), 32'(s_op));
    chk("cmd_addr", 32'(cmd_addr), 32'(s_ad));
    chk("cmd_len", 32'(cmd_len), 32'(s_ln));
    chk1("tx_valid", tx_valid, q.size() != 0);
    if (q.size() != 0) chk("tx_data", tx_data, q[0]);
    chk1("crc_clear", crc_clear, m_crc);
    chk1("error_clear", error_clear, m_err);
    chk1("start_reject", start_reject, m_rej);
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    avs_s0_write = 1'b1; avs_s0_address = a; avs_s0_writedata = d;
    @(negedge clk);
    while (avs_s0_waitrequest && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      misses++;
      $display("FAIL wr_timeout: write to %h still stalled after %0d cycles", a, n);
    end
    sync();
    avs_s0_write = 1'b0;
  endtask

  logic [31:0] words [5] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004, 32'hE4E4_0005};
  logic [11:0] unmapped [4] = '{12'd5, 12'd6, 12'd7, 12'hFFF};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge clk);
    chk1("rst_busy", busy, 0); chk1("rst_cmd_valid", cmd_valid, 0);
    chk1("rst_tx_valid", tx_valid, 0); chk("rst_cmd_len", 32'(cmd_len), 0);
    sync(); rst = 1'b0;

    // command issue
    wr(12'd0, 32'h03); wr(12'd1, 32'h0012_3456); wr(12'd2, 32'd4); wr(12'd4, 32'h1);
    @(negedge clk);
    chk1("iss_valid", cmd_valid, 1); chk("iss_op", 32'(cmd_opcode), 32'h03);
    chk("iss_addr", 32'(cmd_addr), 32'h123456); chk("iss_len", 32'(cmd_len), 4);
    chk1("iss_busy", busy, 1);
    repeat (3) begin
      sync(); @(negedge clk);
      chk1("hold_valid", cmd_valid, 1); chk("hold_addr", 32'(cmd_addr), 32'h123456);
    end
    sync(); cmd_ready = 1'b1;
    sync(); cmd_ready = 1'b0;
    @(negedge clk); chk1("run_valid", cmd_valid, 0); chk1("run_busy", busy, 1);
    sync(); wr(12'd1, 32'h00AB_CDEF); wr(12'd4, 32'h1);
    @(negedge clk); chk1("run_rej", start_reject, 1); chk("run_addr", 32'(cmd_addr), 32'h123456);
    sync(); xfer_done = 1'b1;
    sync(); xfer_done = 1'b0;
    @(negedge clk); chk1("done_busy", busy, 0);

    // zero-length start
    sync(); wr(12'd2, 32'd0); wr(12'd4, 32'h1);
    @(negedge clk); chk1("len0_rej", start_reject, 1); chk1("len0_valid", cmd_valid, 0);
    sync(); @(negedge clk); chk1("len0_rej_end", start_reject, 0);

    // clear pulses
    sync(); wr(12'd4, 32'h6);
    @(negedge clk); chk1("clr_crc", crc_clear, 1); chk1("clr_err", error_clear, 1); chk1("clr_busy", busy, 0);
    sync(); @(negedge clk); chk1("clr_crc_end", crc_clear, 0); chk1("clr_err_end", error_clear, 0);
    sync(); wr(12'd2, 32'd2); wr(12'd4, 32'h7);
    @(negedge clk); chk1("c7_crc", crc_clear, 1); chk1("c7_err", error_clear, 1);
    chk1("c7_valid", cmd_valid, 1); chk("c7_len", 32'(cmd_len), 2);
    sync(); cmd_ready = 1'b1; xfer_done = 1'b1;
    sync(); cmd_ready = 1'b0; xfer_done = 1'b0;
    @(negedge clk); chk1("hs_done_busy", busy, 1); chk1("hs_done_valid", cmd_valid, 0);
    sync(); xfer_done = 1'b1;
    sync(); xfer_done = 1'b0;

    // FIFO full, stall, simultaneous push/pop, ordering
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(12'd3, words[i]);
    @(negedge clk); chk1("ff_valid", tx_valid, 1); chk("ff_head", tx_data, words[0]);
    sync(); avs_s0_write = 1'b1; avs_s0_address = 12'd3; avs_s0_writedata = words[4];
    @(negedge clk); chk1("ff_wait", avs_s0_waitrequest, 1);
    sync(); tx_ready = 1'b1;
    @(negedge clk); chk1("ff_wait_pop", avs_s0_waitrequest, 0);
    sync(); avs_s0_write = 1'b0;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); chk("ff_order", tx_data, words[i]);
      sync();
    end
    tx_ready = 1'b0;
    @(negedge clk); chk1("ff_empty", tx_valid, 0);

    // reset mid-run with queued words
    sync(); wr(12'd3, 32'h1111_1111); wr(12'd3, 32'h2222_2222); wr(12'd4, 32'h1);
    cmd_ready = 1'b1; sync(); cmd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk); chk1("mr_busy", busy, 0); chk1("mr_tx_valid", tx_valid, 0); chk1("mr_cmd_valid", cmd_valid, 0);
    sync(); rst = 1'b0;
    wr(12'd2, 32'd5); wr(12'd4, 32'h1);
    @(negedge clk); chk1("mr_reissue", cmd_valid, 1); chk("mr_len", 32'(cmd_len), 5); chk("mr_op", 32'(cmd_opcode), 0);
    sync(); cmd_ready = 1'b1;
    sync(); cmd_ready = 1'b0; xfer_done = 1'b1;
    sync(); xfer_done = 1'b0;

    // unmapped writes and reads
    foreach (unmapped[i]) wr(unmapped[i], 32'hFFFF_FFFF);
    avs_s0_read = 1'b1;
    for (int a = 0; a < 6; a++) begin avs_s0_address = 12'(a); sync(); end
    avs_s0_read = 1'b0;
    @(negedge clk); chk1("um_busy", busy, 0); chk1("um_tx", tx_valid, 0); chk("um_len", 32'(cmd_len), 5);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int sel;
      logic [31:0] d;
      sel = $urandom_range(0, 11);
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d[15:0] = 16'h0;
      avs_s0_write     = $urandom_range(0, 1) == 1;
      avs_s0_read      = $urandom_range(0, 3) == 0;
      avs_s0_address   = (sel >= 10) ? 12'd3 : (sel == 9) ? 12'hFFF : 12'(sel);
      avs_s0_writedata = d;
      tx_ready  = $urandom_range(0, 2) == 0;
      cmd_ready = $urandom_range(0, 2) == 0;
      xfer_done = $urandom_range(0, 3) == 0;
      rst       = $urandom_range(0, 299) == 0;
      sync();
    end
    avs_s0_write = 1'b0; rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
